// File: rtl/sparse_intersect_unit.sv
// sparse_intersect_unit: fibertree-level coordinate joiner (intersect/union).
// Define INTERSECT_PERF_CNT_EN to add the 64-bit cycle_count output.
module sparse_intersect_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = clk_en & push & ~full;
  assign do_pop  = clk_en & pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

module sparse_intersect_unit #(
  parameter int DATA_W     = 17,
  parameter int FIFO_DEPTH = 2
) (
`ifdef INTERSECT_PERF_CNT_EN
  output logic [63:0]       cycle_count,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic              joiner_op,
  input  logic              vector_reduce_mode,
  input  logic [DATA_W-1:0] coord_in_0,
  input  logic              coord_in_0_valid,
  output logic              coord_in_0_ready,
  input  logic [DATA_W-1:0] coord_in_1,
  input  logic              coord_in_1_valid,
  output logic              coord_in_1_ready,
  input  logic [DATA_W-1:0] pos_in_0,
  input  logic              pos_in_0_valid,
  output logic              pos_in_0_ready,
  input  logic [DATA_W-1:0] pos_in_1,
  input  logic              pos_in_1_valid,
  output logic              pos_in_1_ready,
  output logic [DATA_W-1:0] coord_out,
  output logic              coord_out_valid,
  input  logic              coord_out_ready,
  output logic [DATA_W-1:0] pos_out_0,
  output logic              pos_out_0_valid,
  input  logic              pos_out_0_ready,
  output logic [DATA_W-1:0] pos_out_1,
  output logic              pos_out_1_valid,
  input  logic              pos_out_1_ready
);
  localparam logic [DATA_W-1:0] TK_DONE  = DATA_W'(17'h10100);
  localparam logic [DATA_W-1:0] TK_EMPTY = DATA_W'(17'h10200);
  localparam int F = DATA_W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   live;

  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [3:0]        in_push;
  logic [3:0]        in_pop;
  logic [3:0]        in_full;
  logic [3:0]        in_empty;
  logic [DATA_W-1:0] in_wdata [4];
  logic [DATA_W-1:0] in_rdata [4];

  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [2:0]        out_pop;
  logic [2:0]        out_full;
  logic [2:0]        out_empty;
  logic [DATA_W-1:0] out_wdata [3];
  logic [DATA_W-1:0] out_rdata [3];

  logic accept;
  logic go;
  logic rdy0, rdy1;
  logic dat0, dat1, dn0, dn1, st0, st1;
  logic eq, lt;
  logic emit, pop0, pop1, done_go;
  logic [DATA_W-1:0] c0, p0, c1, p1;
  logic [DATA_W-1:0] e_c, e_p0, e_p1;

  assign in_valid = {pos_in_1_valid, coord_in_1_valid,
                     pos_in_0_valid, coord_in_0_valid};
  assign in_wdata[0] = coord_in_0;
  assign in_wdata[1] = pos_in_0;
  assign in_wdata[2] = coord_in_1;
  assign in_wdata[3] = pos_in_1;

  assign accept   = tile_en & live & (state != S_DONE);
  assign in_ready = ~in_full & {4{accept}};
  assign in_push  = in_valid & in_ready;
  assign in_pop   = {pop1, pop1, pop0, pop0};

  assign coord_in_0_ready = in_ready[0];
  assign pos_in_0_ready   = in_ready[1];
  assign coord_in_1_ready = in_ready[2];
  assign pos_in_1_ready   = in_ready[3];

  assign out_ready = {pos_out_1_ready, pos_out_0_ready, coord_out_ready};
  assign out_valid = ~out_empty & {3{tile_en}};
  assign out_pop   = out_valid & out_ready;
  assign out_wdata[0] = e_c;
  assign out_wdata[1] = e_p0;
  assign out_wdata[2] = e_p1;

  assign coord_out       = out_rdata[0];
  assign pos_out_0       = out_rdata[1];
  assign pos_out_1       = out_rdata[2];
  assign coord_out_valid = out_valid[0];
  assign pos_out_0_valid = out_valid[1];
  assign pos_out_1_valid = out_valid[2];

  for (genvar g = 0; g < 4; g++) begin : g_in
    sparse_intersect_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .flush  (flush),
      .push   (in_push[g]),
      .wdata  (in_wdata[g]),
      .pop    (in_pop[g]),
      .rdata  (in_rdata[g]),
      .full   (in_full[g]),
      .empty  (in_empty[g])
    );
  end

  for (genvar g = 0; g < 3; g++) begin : g_out
    sparse_intersect_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .flush  (flush),
      .push   (emit),
      .wdata  (out_wdata[g]),
      .pop    (out_pop[g]),
      .rdata  (out_rdata[g]),
      .full   (out_full[g]),
      .empty  (out_empty[g])
    );
  end

  assign c0 = in_rdata[0];
  assign p0 = in_rdata[1];
  assign c1 = in_rdata[2];
  assign p1 = in_rdata[3];

  assign rdy0 = ~in_empty[0] & ~in_empty[1];
  assign rdy1 = ~in_empty[2] & ~in_empty[3];
  assign dat0 = ~c0[F];
  assign dat1 = ~c1[F];
  assign dn0  = (c0 == TK_DONE);
  assign dn1  = (c1 == TK_DONE);
  assign st0  = ~dat0 & ~dn0;
  assign st1  = ~dat1 & ~dn1;
  assign eq   = (c0[F-1:0] == c1[F-1:0]);
  assign lt   = (c0[F-1:0] <  c1[F-1:0]);
  assign go   = clk_en & ~(|out_full) & (state != S_DONE);

  // join decision: which operands pop and what is emitted
  always_comb begin
    emit    = 1'b0;
    pop0    = 1'b0;
    pop1    = 1'b0;
    done_go = 1'b0;
    e_c     = '0;
    e_p0    = '0;
    e_p1    = '0;
    if (go) begin
      if (vector_reduce_mode) begin
        if (rdy0 && rdy1 && dn0 && dn1) begin
          emit = 1'b1; pop0 = 1'b1; pop1 = 1'b1; done_go = 1'b1;
          e_c = TK_DONE; e_p0 = TK_DONE; e_p1 = TK_DONE;
        end else begin
          if (rdy0 && !dn0) begin
            emit = 1'b1; pop0 = 1'b1;
            e_c = c0; e_p0 = p0; e_p1 = p0;
          end
          if (rdy1 && !dn1) pop1 = 1'b1;
        end
      end else if (rdy0 && rdy1) begin
        unique case (1'b1)
          dat0 && dat1: begin
            if (eq) begin
              emit = 1'b1; pop0 = 1'b1; pop1 = 1'b1;
              e_c = c0; e_p0 = p0; e_p1 = p1;
            end else if (lt) begin
              pop0 = 1'b1; emit = joiner_op;
              e_c = c0; e_p0 = p0; e_p1 = TK_EMPTY;
            end else begin
              pop1 = 1'b1; emit = joiner_op;
              e_c = c1; e_p0 = TK_EMPTY; e_p1 = p1;
            end
          end
          dat0 && !dat1: begin
            pop0 = 1'b1; emit = joiner_op;
            e_c = c0; e_p0 = p0; e_p1 = TK_EMPTY;
          end
          !dat0 && dat1: begin
            pop1 = 1'b1; emit = joiner_op;
            e_c = c1; e_p0 = TK_EMPTY; e_p1 = p1;
          end
          dn0 && dn1: begin
            emit = 1'b1; pop0 = 1'b1; pop1 = 1'b1; done_go = 1'b1;
            e_c = TK_DONE; e_p0 = TK_DONE; e_p1 = TK_DONE;
          end
          dn0 && st1: pop1 = 1'b1;
          st0 && dn1: pop0 = 1'b1;
          default: begin
            emit = 1'b1; pop0 = 1'b1; pop1 = 1'b1;
            e_c = c0; e_p0 = c0; e_p1 = c0;
          end
        endcase
      end
    end
  end

  // control FSM; live holds readies low for the cycle after reset/flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      live  <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      live  <= 1'b0;
    end else if (clk_en) begin
      live <= 1'b1;
      if (done_go) state <= S_DONE;
      else if (state == S_IDLE && (pop0 || pop1)) state <= S_RUN;
    end
  end

`ifdef INTERSECT_PERF_CNT_EN
  logic cnt_started;
  logic cnt_stopped;

  // cycles from first input activity until DONE leaves on pos_out_0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      cnt_started <= 1'b0;
      cnt_stopped <= 1'b0;
    end else if (flush) begin
      cycle_count <= '0;
      cnt_started <= 1'b0;
      cnt_stopped <= 1'b0;
    end else if (clk_en) begin
      if (!cnt_stopped && (cnt_started || (|in_valid))) begin
        cycle_count <= cycle_count + 64'd1;
        cnt_started <= 1'b1;
      end
      if (out_pop[1] && out_rdata[1] == TK_DONE) cnt_stopped <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sparse_intersect_unit.sv
// tb_sparse_intersect_unit: streams fibers through the joiner and compares
// every output channel against a set-level reference model.
module tb_sparse_intersect_unit;
  localparam logic [16:0] S0 = 17'h10000;
  localparam logic [16:0] S1 = 17'h10001;
  localparam logic [16:0] DN = 17'h10100;
  localparam logic [16:0] EM = 17'h10200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic flush = 1'b0;
  logic tile_en = 1'b1;
  logic joiner_op = 1'b0;
  logic vrm = 1'b0;

  logic [3:0]        in_v;
  logic [3:0][16:0]  in_d;
  wire  [3:0]        in_r;
  logic [2:0]        out_r;
  wire  [2:0]        out_v;
  wire  [2:0][16:0]  out_d;

  logic [16:0] src [4][64];
  int          src_len [4];
  logic [16:0] expq [3][128];
  int          exp_len [3];
  logic [16:0] rcv [3][128];
  int          rcv_len [3];
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  sparse_intersect_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clk_en             (clk_en),
    .flush              (flush),
    .tile_en            (tile_en),
    .joiner_op          (joiner_op),
    .vector_reduce_mode (vrm),
    .coord_in_0         (in_d[0]),
    .coord_in_0_valid   (in_v[0]),
    .coord_in_0_ready   (in_r[0]),
    .pos_in_0           (in_d[1]),
    .pos_in_0_valid     (in_v[1]),
    .pos_in_0_ready     (in_r[1]),
    .coord_in_1         (in_d[2]),
    .coord_in_1_valid   (in_v[2]),
    .coord_in_1_ready   (in_r[2]),
    .pos_in_1           (in_d[3]),
    .pos_in_1_valid     (in_v[3]),
    .pos_in_1_ready     (in_r[3]),
    .coord_out          (out_d[0]),
    .coord_out_valid    (out_v[0]),
    .coord_out_ready    (out_r[0]),
    .pos_out_0          (out_d[1]),
    .pos_out_0_valid    (out_v[1]),
    .pos_out_0_ready    (out_r[1]),
    .pos_out_1          (out_d[2]),
    .pos_out_1_valid    (out_v[2]),
    .pos_out_1_ready    (out_r[2])
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < 4; k++) src_len[k] = 0;
  endtask

  task automatic put(input int k, input logic [16:0] c, input logic [16:0] p);
    src[2*k][src_len[2*k]] = c;
    src_len[2*k]++;
    src[2*k+1][src_len[2*k+1]] = p;
    src_len[2*k+1]++;
  endtask

  task automatic add(input logic [16:0] c, input logic [16:0] a,
                     input logic [16:0] b);
    expq[0][exp_len[0]] = c; exp_len[0]++;
    expq[1][exp_len[1]] = a; exp_len[1]++;
    expq[2][exp_len[2]] = b; exp_len[2]++;
  endtask

  // fiber-by-fiber set join: intersection or union of coordinate sets
  task automatic build_expected(input bit u);
    int i, j, ie, je, fa, fb;
    i = 0; j = 0;
    exp_len = '{0, 0, 0};
    while (src[0][i] != DN) begin
      ie = i; je = j;
      while (!src[0][ie][16]) ie++;
      while (!src[2][je][16]) je++;
      for (int x = 0; x < 64; x++) begin
        fa = -1; fb = -1;
        for (int t = i; t < ie; t++) if (int'(src[0][t][15:0]) == x) fa = t;
        for (int t = j; t < je; t++) if (int'(src[2][t][15:0]) == x) fb = t;
        if (fa >= 0 && fb >= 0) add(17'(x), src[1][fa], src[3][fb]);
        else if (u && fa >= 0) add(17'(x), src[1][fa], EM);
        else if (u && fb >= 0) add(17'(x), EM, src[3][fb]);
      end
      add(src[0][ie], src[0][ie], src[0][ie]);
      i = ie + 1; j = je + 1;
    end
    add(DN, DN, DN);
  endtask

  task automatic load_plan();
    clear_src();
    put(0, 17'd1, 17'd0); put(0, 17'd3, 17'd1); put(0, 17'd5, 17'd2);
    put(0, S0, S0); put(0, DN, DN);
    put(1, 17'd3, 17'd0); put(1, 17'd4, 17'd1); put(1, 17'd5, 17'd2);
    put(1, S0, S0); put(1, DN, DN);
  endtask

  task automatic load_empty();
    clear_src();
    for (int k = 0; k < 2; k++) begin
      put(k, S0, S0); put(k, S1, S1); put(k, DN, DN);
    end
  endtask

  task automatic load_long();
    clear_src();
    for (int x = 0; x < 12; x++) put(0, 17'(2 * x), 17'(x));
    for (int x = 0; x < 12; x++) put(1, 17'(3 * x), 17'(x + 100));
    put(0, S0, S0); put(0, DN, DN);
    put(1, S0, S0); put(1, DN, DN);
  endtask

  task automatic load_random();
    int nf;
    int pc [2];
    clear_src();
    nf = 1 + int'($urandom_range(2));
    pc = '{0, 0};
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < 2; k++) begin
        for (int x = 0; x < 16; x++) begin
          if ($urandom_range(1) == 1) begin
            put(k, 17'(x), 17'(pc[k]));
            pc[k]++;
          end
        end
        put(k, (f == nf - 1) ? S1 : S0, (f == nf - 1) ? S1 : S0);
      end
    end
    put(0, DN, DN); put(1, DN, DN);
  endtask

  // drive sources, collect sinks, optional stall or mid-stream abort
  task automatic run_case(input bit u, input bit thr, input int stall_at,
                          input int abort_at, input int abort_kind);
    int  idx [4];
    bit  xin [4];
    bit  done;
    int  held;
    idx = '{0, 0, 0, 0};
    rcv_len = '{0, 0, 0};
    done = 0; held = 0;
    joiner_op = u;
    in_v = '0; in_d = '0; out_r = 3'b111;
    flush = 1'b1; @(posedge clk); #1;
    flush = 1'b0; @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      in_v[k] = (src_len[k] > 0);
      in_d[k] = src[k][0];
    end
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) xin[k] = in_v[k] & in_r[k];
      for (int o = 0; o < 3; o++)
        if (out_v[o] && out_r[o] && rcv_len[o] < 128) begin
          rcv[o][rcv_len[o]] = out_d[o];
          rcv_len[o]++;
        end
      if (abort_at > 0 && rcv_len[0] >= abort_at) begin
        in_v = '0;
        if (abort_kind == 1) begin
          rst_n = 1'b0; #1;
          check_eq("rst_mid_valid", 64'(out_v), 64'd0);
          check_eq("rst_mid_ready", 64'(in_r), 64'd0);
          @(posedge clk); #1;
          rst_n = 1'b1;
        end else begin
          flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
          check_eq("flush_mid_valid", 64'(out_v), 64'd0);
          check_eq("flush_mid_ready", 64'(in_r), 64'd0);
        end
        return;
      end
      if (rcv_len[0] == exp_len[0] && rcv_len[1] == exp_len[1] &&
          rcv_len[2] == exp_len[2]) begin
        done = 1;
      end else begin
        if (stall_at > 0 && cyc == stall_at + 1) held = rcv_len[0];
        if (stall_at > 0 && cyc == stall_at + 19) begin
          check_eq("stall_in_ready", 64'(in_r), 64'd0);
          check_eq("stall_no_coord", 64'(rcv_len[0]), 64'(held));
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
          if (xin[k]) idx[k]++;
          in_v[k] = (idx[k] < src_len[k]) && (!thr || $urandom_range(2) != 0);
          in_d[k] = (idx[k] < src_len[k]) ? src[k][idx[k]] : 17'd0;
        end
        for (int o = 0; o < 3; o++)
          out_r[o] = !thr || $urandom_range(2) != 0;
        if (stall_at > 0 && cyc >= stall_at && cyc < stall_at + 20)
          out_r[0] = 1'b0;
      end
    end
    check_eq("finished", 64'(done), 64'd1);
    in_v = '0;
    @(posedge clk); #1;
    check_eq("done_in_ready", 64'(in_r), 64'd0);
    check_eq("done_out_valid", 64'(out_v), 64'd0);
    for (int o = 0; o < 3; o++) begin
      check_eq($sformatf("len%0d", o), 64'(rcv_len[o]), 64'(exp_len[o]));
      for (int i = 0; i < exp_len[o]; i++)
        check_eq($sformatf("out%0d[%0d]", o, i),
                 64'((i < rcv_len[o]) ? rcv[o][i] : 17'h1ffff),
                 64'(expq[o][i]));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_v = '0;
    in_d = '0;
    out_r = 3'b111;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_v), 64'd0);
    check_eq("rst_in_ready", 64'(in_r), 64'd0);
    check_eq("rst_out_data", 64'(out_d), 64'd0);
    rst_n = 1'b1;

    load_plan(); build_expected(0); run_case(0, 0, 0, 0, 0);
    load_plan(); build_expected(1); run_case(1, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      load_plan(); build_expected(0); run_case(0, 1, 0, 0, 0);
    end
    load_empty(); build_expected(0); run_case(0, 0, 0, 0, 0);
    load_empty(); build_expected(1); run_case(1, 1, 0, 0, 0);
    load_long(); build_expected(1); run_case(1, 0, 4, 0, 0);

    load_plan(); build_expected(0); run_case(0, 0, 0, 2, 1);
    load_plan(); build_expected(0); run_case(0, 1, 0, 0, 0);
    load_plan(); build_expected(1); run_case(1, 0, 0, 2, 2);
    load_plan(); build_expected(1); run_case(1, 1, 0, 0, 0);

    for (int r = 0; r < 10; r++) begin
      bit u;
      u = 1'($urandom_range(1));
      load_random();
      build_expected(u);
      run_case(u, 1, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
